// File: rtl/memory_alert_logger.sv
// Alert logger: captures one entry per rising alert into a FIFO, with per-module saturating
// alert counters and sticky lockout. Define ALERT_LOG_TIMESTAMP_EN to add an 8-bit timestamp.
module memory_alert_logger #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned LOCK_THRESH = 3,
`ifdef ALERT_LOG_TIMESTAMP_EN
  parameter int unsigned ENTRY_W     = 18
`else
  parameter int unsigned ENTRY_W     = 10
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alert_valid,
  input  logic [1:0]         alert_module_id,
  input  logic [3:0]         alert_addr,
  input  logic [3:0]         alert_data,
  input  logic               log_ready,
  input  logic               clear_status,
  output logic               log_valid,
  output logic [ENTRY_W-1:0] log_entry,
  output logic [4:0]         fifo_count,
  output logic               fifo_full,
  output logic               overflow,
  output logic [3:0]         lockout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic               prev_q;
  logic               overflow_q, overflow_d;
  logic [3:0]         lockout_q, lockout_d;
  logic [2:0]         cnt_q [4];
  logic [2:0]         cnt_d [4];

  logic               evt, full, pop, push;
  logic [ENTRY_W-1:0] entry;

`ifdef ALERT_LOG_TIMESTAMP_EN
  logic [7:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= 8'd0;
    else     ts_q <= ts_q + 8'd1;
  end

  assign entry = {ts_q, alert_module_id, alert_addr, alert_data};
`else
  assign entry = {alert_module_id, alert_addr, alert_data};
`endif

  always_comb begin
    evt  = alert_valid & ~prev_q;
    full = (count_q == 5'(DEPTH));
    pop  = (count_q != 5'd0) & log_ready;
    // A full FIFO still accepts an event when the head leaves on the same edge.
    push = evt & (~full | pop);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 5'd1;
    else if (pop && !push) count_d = count_q - 5'd1;

    overflow_d = clear_status ? 1'b0 : (overflow_q | (evt & full & ~pop));

    lockout_d = lockout_q;
    for (int m = 0; m < 4; m++) begin
      cnt_d[m] = cnt_q[m];
      if (evt && alert_module_id == 2'(m) && cnt_q[m] != 3'd7) cnt_d[m] = cnt_q[m] + 3'd1;
      if (cnt_d[m] >= 3'(LOCK_THRESH)) lockout_d[m] = 1'b1;
      if (clear_status) begin
        cnt_d[m]     = 3'd0;
        lockout_d[m] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      prev_q     <= 1'b0;
      overflow_q <= 1'b0;
      lockout_q  <= 4'd0;
      for (int m = 0; m < 4; m++) cnt_q[m] <= 3'd0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_q     <= alert_valid;
      overflow_q <= overflow_d;
      lockout_q  <= lockout_d;
      for (int m = 0; m < 4; m++) cnt_q[m] <= cnt_d[m];
      if (push) mem_q[wr_ptr_q] <= entry;
    end
  end

  always_comb begin
    log_valid  = (count_q != 5'd0);
    log_entry  = mem_q[rd_ptr_q];
    fifo_count = count_q;
    fifo_full  = full;
    overflow   = overflow_q;
    lockout    = lockout_q;
  end

endmodule
